// File: rtl/tds_channel_merger.sv
// rtl/tds_channel_merger.sv - multi-channel TDS frame FIFOs merged round-robin onto one output stream
//
// Ports:
//   clk_readout, reset_n       sole clock (rising edge), asynchronous active-low reset
//   enable, flush              global write enable, synchronous clear of FIFOs and output stage
//   tds_mode, linked, in_valid per-channel mode (1 strip / 0 pad), link-up flag and frame strobe
//   in_data                    channel i frame at [i*DATA_W +: DATA_W]
//   data_tran_stop             blocks new output loads without retracting the presented word
//   out_valid/out_ready        output handshake; out_data/out_chan carry frame and source channel
//   fifo_empty, fifo_full      registered per-channel FIFO status
//   overflow_cnt               saturating per-channel dropped-frame counts, channel i at [i*CNT_W +: CNT_W]
module tds_channel_merger #(
  parameter int NCH    = 4,
  parameter int DATA_W = 120,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8,
  localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk_readout,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [NCH-1:0]          tds_mode,
  input  logic [NCH-1:0]          linked,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*DATA_W-1:0]   in_data,
  input  logic                    data_tran_stop,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_chan,
  output logic [NCH-1:0]          fifo_empty,
  output logic [NCH-1:0]          fifo_full,
  output logic [NCH*CNT_W-1:0]    overflow_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        mem_q [NCH][DEPTH];
  logic [AW-1:0]            wptr_q [NCH], wptr_d [NCH];
  logic [AW-1:0]            rptr_q [NCH], rptr_d [NCH];
  logic [AW:0]              cnt_q [NCH], cnt_d [NCH];
  logic [NCH-1:0]           empty_q, empty_d, full_q, full_d;
  logic [NCH-1:0]           wr_en, drop, pop;
  logic [NCH-1:0][CNT_W-1:0] ovf_q, ovf_d;
  logic [DATA_W-1:0]        wr_word [NCH];
  logic [ID_W-1:0]          ptr_q, ptr_d, grant, out_chan_q, out_chan_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     found, load;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (!found && !empty_q[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  // With only two states, "EMPTY or (HOLD and out_ready)" reduces to this.
  assign load = ((state_q == ST_EMPTY) || out_ready) && !data_tran_stop && found && !flush;

  // Per-channel FIFO bookkeeping. Status flags are registered, so a write
  // arriving while full_q is set is dropped even if a pop happens this cycle.
  // The ring keeps one slot free, so a FIFO reports full at DEPTH-1 entries.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = in_valid[i] & linked[i] & enable & ~full_q[i] & ~flush;
      drop[i]  = in_valid[i] & linked[i] & enable & full_q[i];
      pop[i]   = load && (grant == ID_W'(i));

      wr_word[i] = in_data[i*DATA_W +: DATA_W];
      if (tds_mode[i]) begin
        wr_word[i][DATA_W-1 -: 16] = 16'hFFFF;
      end else begin
        wr_word[i][DATA_W-1 -: 4] = 4'h0;
      end

      if (flush) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        wptr_d[i] = wptr_q[i] + AW'(wr_en[i]);
        rptr_d[i] = rptr_q[i] + AW'(pop[i]);
        cnt_d[i]  = cnt_q[i] + (AW+1)'(wr_en[i]) - (AW+1)'(pop[i]);
      end
      empty_d[i] = (cnt_d[i] == '0);
      full_d[i]  = (cnt_d[i] == (AW+1)'(DEPTH-1));

      ovf_d[i] = ovf_q[i];
      if (drop[i] && (ovf_q[i] != {CNT_W{1'b1}})) begin
        ovf_d[i] = ovf_q[i] + CNT_W'(1);
      end
    end
  end

  // Output stage next-state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      state_d = ST_HOLD;
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Output stage data path: registers change only on a load.
  always_comb begin
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    ptr_d      = ptr_q;
    if (load) begin
      out_data_d = mem_q[grant][rptr_q[grant]];
      out_chan_d = grant;
      ptr_d      = grant;
    end
  end

  // Output stage outputs.
  always_comb begin
    out_valid = (state_q == ST_HOLD);
  end

  assign out_data     = out_data_q;
  assign out_chan     = out_chan_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign overflow_cnt = ovf_q;

  always_ff @(posedge clk_readout or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= ID_W'(NCH - 1);  // next search starts at channel 0
      empty_q    <= '1;
      full_q     <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q      <= ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Frame storage needs no reset: pointers and counts define validity.
  always_ff @(posedge clk_readout) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wptr_q[i]] <= wr_word[i];
      end
    end
  end

endmodule
